seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Multi-cycle, parametrised-width successor to the datapath ALU, built for the Phase 3 control unit.
- Single-cycle logic, shift and rotate ops complete in one clock.
- MUL and DIV are iterative: radix-2 shift-add and restoring division, one bit per clock.
- Control unit issues an op with start/ready and samples the 2*WIDTH result (into HI/LO or Z) when done pulses.

Parameters:
- WIDTH, 32: operand width; must be a power of 2 and at least 8.
- SHW, $clog2(WIDTH): derived, not overridable; number of shift-amount bits taken from b.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when ready=1
- flush  in  1  synchronous abort of an in-flight op
- op  in  5  operation code, sampled on accept
- a  in  WIDTH  operand A, sampled on accept
- b  in  WIDTH  operand B, sampled on accept
- ready  out  1  idle, can accept an op
- done  out  1  one-cycle pulse: result valid
- result  out  2*WIDTH  low half = main result / quotient / product low; high half = remainder / product high
- div_zero  out  1  valid with done: DIV with b=0
- illegal  out  1  valid with done: op code not recognised

Behaviour:
- Reset (clr=0, asynchronous) sets: state IDLE, ready=1, done=0, result=0, div_zero=0, illegal=0. A reset mid-operation discards that op.
- Op codes, unchanged from the existing ALU:
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NEG a, 6 NOT a
  - 7 SHR (logical), 8 SHL, 9 ROR, 10 ROL
  - 11 DIV, 12 MUL, 13 SHRA (arithmetic), 14 INCPC (b+1)
  - Every other code (including 0 and 15-31) is illegal.
- Accept: on a rising edge with start=1 and ready=1, latch op, a and b. A start while ready=0 is ignored, with no queueing.
- States: IDLE, MUL, DIV, FIX.
- Simple ops (1-10, 13, 14):
  - Result registered on the accept edge; high half = 0; done=1 for the following cycle. Latency 1.
  - State stays IDLE and ready stays 1, so back-to-back issue is allowed every cycle.
  - Add and sub wrap modulo 2^WIDTH, with no carry out.
  - Shifts and rotates use b[SHW-1:0] only.
- Illegal op: same timing as a simple op; result=0, illegal=1 with done.
- MUL, two's-complement signed:
  - Accept edge: operand magnitudes and sign latched, ready drops to 0, state MUL.
  - WIDTH iteration edges, then one FIX edge that applies the sign and registers result.
  - done pulses in the cycle after FIX, with ready=1 again. Latency WIDTH+2 from accept.
  - Full 2*WIDTH product; no overflow possible.
- DIV, signed:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Same timing as MUL (state DIV then FIX, latency WIDTH+2).
  - b=0: skip the iterations and go straight to FIX. Quotient = all ones, remainder = a, div_zero=1. Latency 2.
  - a = most negative value, b = -1: quotient = most negative value, remainder = 0, no flag.
- Flag timing: div_zero and illegal are valid only while done=1 and are cleared on the next accept.
- result holds its value between done pulses.
- flush=1 on any edge forces IDLE and ready=1, with no done. The held result is unchanged.
- flush and start together: flush wins and the start is dropped.
- Iteration counter is SHW+1 bits and counts WIDTH down to 0. It must not wrap.

Decomposition:
- seq_alu_pkg holds:
  - the op-code localparams (OP_ADD ... OP_INCPC)
  - the state encoding (IDLE=0, MUL=1, DIV=2, FIX=3)
- One sub-module, seq_alu_iter: the shared shift/subtract-or-add datapath used by both MUL and DIV, selected by a mode bit.
- Simple ops stay inline as one combinational case feeding the result register.

Test Plan:
- ADD a=32'h7FFF_FFFF, b=1 -> done 1 cycle later, result=64'h0000_0000_8000_0000. Back-to-back SUB 5-7 next cycle -> 32'hFFFF_FFFE.
- MUL a=-3, b=7 -> ready low for 33 cycles; done at accept+34; result=64'hFFFF_FFFF_FFFF_FFEB. A start during busy is ignored.
- DIV a=-7, b=2 -> low=32'hFFFF_FFFD (-3), high=32'hFFFF_FFFF (-1), latency 34. DIV a=9, b=0 -> latency 2, div_zero=1, low=all ones, high=9.
- ROR a=32'h0000_0001, b=32'h0000_0021 (shift amount 1) -> 32'h8000_0000. SHRA a=32'h8000_0000, b=4 -> 32'hF800_0000.
- op=0 and op=15 -> done after 1 cycle, illegal=1, result=0.
- MUL started, flush at iteration 10 -> ready=1 next cycle, no done, result unchanged. Repeat the test with clr pulsed low mid-DIV -> all outputs reset immediately (asynchronously).

Source files
------------

// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_alu_pkg
// Brief   : Op-code values and controller state encoding for seq_alu.
// Rev     : 1.0  initial release
// ============================================================================
package seq_alu_pkg;

  // Op codes are kept bit-identical to the single-cycle datapath ALU.
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_NEG   = 5'd5;
  localparam logic [4:0] OP_NOT   = 5'd6;
  localparam logic [4:0] OP_SHR   = 5'd7;
  localparam logic [4:0] OP_SHL   = 5'd8;
  localparam logic [4:0] OP_ROR   = 5'd9;
  localparam logic [4:0] OP_ROL   = 5'd10;
  localparam logic [4:0] OP_DIV   = 5'd11;
  localparam logic [4:0] OP_MUL   = 5'd12;
  localparam logic [4:0] OP_SHRA  = 5'd13;
  localparam logic [4:0] OP_INCPC = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_alu_iter.sv
`default_nettype none
// ============================================================================
// Module  : seq_alu_iter
// Brief   : One radix-2 step of unsigned shift-add multiply or restoring
//           divide on a {hi, lo} accumulator pair.
// Rev     : 1.0  initial release
// ============================================================================
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             mul_mode_i,  // 1: multiply step, 0: divide step
  input  logic [WIDTH-1:0] hi_i,        // partial product high / partial remainder
  input  logic [WIDTH-1:0] lo_i,        // multiplier bits / dividend-quotient bits
  input  logic [WIDTH-1:0] m_i,         // multiplicand / divisor magnitude
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   w_sum;   // hi + (multiplier LSB ? multiplicand : 0), with carry
  logic [WIDTH:0]   w_shr;   // remainder shifted left, next dividend bit brought in
  logic [WIDTH-1:0] w_rem;   // trial remainder; fits WIDTH bits whenever it is kept
  logic             w_ge;

  // Multiply shifts the carry-extended sum right into lo; divide shifts left and
  // keeps the trial subtraction only when it does not go negative.
  always_comb begin
    w_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
    w_shr = {hi_i, lo_i[WIDTH-1]};
    w_ge  = (w_shr >= {1'b0, m_i});
    w_rem = w_shr[WIDTH-1:0] - m_i;
    hi_o  = hi_i;
    lo_o  = lo_i;
    if (mul_mode_i) begin
      hi_o = w_sum[WIDTH:1];
      lo_o = {w_sum[0], lo_i[WIDTH-1:1]};
    end else if (w_ge) begin
      hi_o = w_rem;
      lo_o = {lo_i[WIDTH-2:0], 1'b1};
    end else begin
      hi_o = w_shr[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module  : seq_alu
// Brief   : Multi-cycle ALU: single-cycle logic/shift ops, iterative signed
//           MUL and DIV (one bit per clock) with start/ready/done handshake.
// Rev     : 1.0  initial release
// ============================================================================
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,       // asynchronous, active low
  input  logic               start,
  input  logic               flush,
  input  logic [4:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero,
  output logic               illegal
);

  localparam int             SHW      = $clog2(WIDTH);
  localparam logic [SHW:0]   CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0]   CNT_ONE  = (SHW+1)'(1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [SHW:0]         cnt_q, cnt_d;
  logic                 is_mul_q, is_mul_d;
  logic                 sgn_lo_q, sgn_lo_d;   // negate low half (or whole product for MUL)
  logic                 sgn_hi_q, sgn_hi_d;   // negate remainder
  logic                 dz_pend_q, dz_pend_d; // divide-by-zero, reported at FIX
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 div_zero_q, div_zero_d;
  logic                 illegal_q, illegal_d;

  logic [WIDTH-1:0]     w_abs_a, w_abs_b, w_simple, w_hi_nx, w_lo_nx;
  logic [SHW-1:0]       w_sh;
  logic [SHW:0]         w_shc;
  logic                 w_legal;
  logic [2*WIDTH-1:0]   w_prod, w_fix;

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .mul_mode_i (is_mul_q),
    .hi_i       (hi_q),
    .lo_i       (lo_q),
    .m_i        (m_q),
    .hi_o       (w_hi_nx),
    .lo_o       (w_lo_nx)
  );

  // Single-cycle ops; rotates use the complementary shift (a<<WIDTH yields 0).
  always_comb begin
    w_sh     = b[SHW-1:0];
    w_shc    = CNT_INIT - {1'b0, w_sh};
    w_abs_a  = a[WIDTH-1] ? -a : a;
    w_abs_b  = b[WIDTH-1] ? -b : b;
    w_legal  = 1'b1;
    w_simple = '0;
    case (op)
      OP_ADD:   w_simple = a + b;
      OP_SUB:   w_simple = a - b;
      OP_AND:   w_simple = a & b;
      OP_OR:    w_simple = a | b;
      OP_NEG:   w_simple = -a;
      OP_NOT:   w_simple = ~a;
      OP_SHR:   w_simple = a >> w_sh;
      OP_SHL:   w_simple = a << w_sh;
      OP_ROR:   w_simple = (a >> w_sh) | (a << w_shc);
      OP_ROL:   w_simple = (a << w_sh) | (a >> w_shc);
      OP_SHRA:  w_simple = $signed(a) >>> w_sh;
      OP_INCPC: w_simple = b + WIDTH'(1);
      default:  w_legal  = 1'b0;
    endcase
  end

  // Sign fix-up of the unsigned magnitude result.
  always_comb begin
    w_prod = {hi_q, lo_q};
    if (is_mul_q) begin
      w_fix = sgn_lo_q ? -w_prod : w_prod;
    end else begin
      w_fix = {(sgn_hi_q ? -hi_q : hi_q), (sgn_lo_q ? -lo_q : lo_q)};
    end
  end

  // Controller next-state and datapath register inputs.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    is_mul_d   = is_mul_q;
    sgn_lo_d   = sgn_lo_q;
    sgn_hi_d   = sgn_hi_q;
    dz_pend_d  = dz_pend_q;
    done_d     = 1'b0;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    illegal_d  = illegal_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            div_zero_d = 1'b0;
            illegal_d  = 1'b0;
            case (op)
              OP_MUL: begin
                state_d  = ST_MUL;
                is_mul_d = 1'b1;
                hi_d     = '0;
                lo_d     = w_abs_b;
                m_d      = w_abs_a;
                sgn_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
                cnt_d    = CNT_INIT;
              end
              OP_DIV: begin
                is_mul_d = 1'b0;
                sgn_hi_d = a[WIDTH-1];
                if (b == '0) begin
                  // Quotient forced to all ones, remainder reconstructs a.
                  state_d   = ST_FIX;
                  hi_d      = w_abs_a;
                  lo_d      = '1;
                  sgn_lo_d  = 1'b0;
                  dz_pend_d = 1'b1;
                end else begin
                  state_d   = ST_DIV;
                  hi_d      = '0;
                  lo_d      = w_abs_a;
                  m_d       = w_abs_b;
                  sgn_lo_d  = a[WIDTH-1] ^ b[WIDTH-1];
                  dz_pend_d = 1'b0;
                  cnt_d     = CNT_INIT;
                end
              end
              default: begin
                done_d    = 1'b1;
                result_d  = {{WIDTH{1'b0}}, w_simple};
                illegal_d = ~w_legal;
              end
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          hi_d  = w_hi_nx;
          lo_d  = w_lo_nx;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          result_d   = w_fix;
          div_zero_d = dz_pend_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset discards any op in flight.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      is_mul_q   <= 1'b0;
      sgn_lo_q   <= 1'b0;
      sgn_hi_q   <= 1'b0;
      dz_pend_q  <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      is_mul_q   <= is_mul_d;
      sgn_lo_q   <= sgn_lo_d;
      sgn_hi_q   <= sgn_hi_d;
      dz_pend_q  <= dz_pend_d;
      done_q     <= done_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign div_zero = div_zero_q;
  assign illegal  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_alu
// Brief   : Directed self-checking bench for seq_alu (WIDTH=32).
// Rev     : 1.0  initial release
// ============================================================================
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  logic           clk;
  logic           clr;
  logic           start;
  logic           flush;
  logic [4:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           done;
  logic [2*W-1:0] result;
  logic           div_zero;
  logic           illegal;

  int   total = 0;
  int   bad   = 0;
  int   lat;
  int   rlow;
  logic seen;

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .flush    (flush),
    .op       (op),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .div_zero (div_zero),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  // Issue at a falling edge; n counts falling edges until done (bounded).
  task automatic long_op(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int n);
    drive(o, x, y);
    @(negedge clk);
    n = 1;
    start = 1'b0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",    64'(ready),    64'd1);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_result",   result,        64'd0);
    chk("rst_divzero",  64'(div_zero), 64'd0);
    chk("rst_illegal",  64'(illegal),  64'd0);
    clr = 1'b1;
    @(negedge clk);

    // ADD overflow wraps, then back-to-back SUB
    drive(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    @(negedge clk);
    chk("add_done",   64'(done), 64'd1);
    chk("add_result", result,    64'h0000_0000_8000_0000);
    drive(OP_SUB, 32'd5, 32'd7);
    @(negedge clk);
    chk("sub_done",   64'(done), 64'd1);
    chk("sub_result", result,    64'h0000_0000_FFFF_FFFE);
    start = 1'b0;
    @(negedge clk);
    chk("idle_done",  64'(done), 64'd0);
    chk("hold_result", result,   64'h0000_0000_FFFF_FFFE);

    // Illegal codes
    drive(5'd0, 32'h1234, 32'h5678);
    @(negedge clk);
    chk("op0_done",    64'(done),    64'd1);
    chk("op0_illegal", 64'(illegal), 64'd1);
    chk("op0_result",  result,       64'd0);
    drive(5'd15, 32'hFFFF, 32'h1);
    @(negedge clk);
    chk("op15_illegal", 64'(illegal), 64'd1);
    chk("op15_result",  result,       64'd0);

    // Shifts / rotates use only the low SHW bits of b
    drive(OP_ROR, 32'h0000_0001, 32'h0000_0021);
    @(negedge clk);
    chk("ror_result",  result,       64'h0000_0000_8000_0000);
    chk("ror_illegal", 64'(illegal), 64'd0);
    drive(OP_SHRA, 32'h8000_0000, 32'd4);
    @(negedge clk);
    chk("shra_result", result, 64'h0000_0000_F800_0000);
    drive(OP_ROL, 32'h8000_0001, 32'd4);
    @(negedge clk);
    chk("rol_result", result, 64'h0000_0000_0000_0018);
    drive(OP_INCPC, 32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("incpc_wrap", result, 64'd0);
    start = 1'b0;

    // MUL -3*7 with an ignored start while busy
    rlow = 0;
    lat  = 0;
    drive(OP_MUL, 32'hFFFF_FFFD, 32'd7);
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) drive(OP_ADD, 32'd1, 32'd1);
      else start = 1'b0;
      if (ready === 1'b0) rlow++;
    end while (done !== 1'b1 && lat < 200);
    chk("mul_latency",  64'(lat),   64'd34);
    chk("mul_busy",     64'(rlow),  64'd33);
    chk("mul_result",   result,     64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_ready",    64'(ready), 64'd1);
    @(negedge clk);
    chk("mul_no_extra", 64'(done),  64'd0);

    long_op(OP_MUL, 32'h1234_5678, 32'h10, lat);
    chk("mul2_result", result, 64'h0000_0001_2345_6780);

    // DIV cases
    long_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div_latency", 64'(lat),      64'd34);
    chk("div_result",  result,        64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_flag",    64'(div_zero), 64'd0);
    long_op(OP_DIV, 32'd9, 32'd0, lat);
    chk("div0_latency", 64'(lat),      64'd2);
    chk("div0_flag",    64'(div_zero), 64'd1);
    chk("div0_result",  result,        64'h0000_0009_FFFF_FFFF);
    long_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("divmin_result", result,        64'h0000_0000_8000_0000);
    chk("divmin_flag",   64'(div_zero), 64'd0);
    long_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, lat);
    chk("div100_result", result, 64'h0000_0002_FFFF_FFF2);

    // flush wins over a simultaneous start
    @(negedge clk);
    drive(OP_ADD, 32'd1, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("fs_done",   64'(done),  64'd0);
    chk("fs_result", result,     64'h0000_0002_FFFF_FFF2);

    // flush mid-MUL
    drive(OP_MUL, 32'd5, 32'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready",  64'(ready), 64'd1);
    chk("flush_done",   64'(done),  64'd0);
    chk("flush_result", result,     64'h0000_0002_FFFF_FFF2);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("flush_no_done", 64'(seen), 64'd0);

    // asynchronous reset mid-DIV
    drive(OP_DIV, 32'd100, 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("clr_ready",   64'(ready),    64'd1);
    chk("clr_done",    64'(done),     64'd0);
    chk("clr_result",  result,        64'd0);
    chk("clr_divzero", 64'(div_zero), 64'd0);
    chk("clr_illegal", 64'(illegal),  64'd0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    drive(OP_ADD, 32'd2, 32'd3);
    @(negedge clk);
    start = 1'b0;
    chk("post_clr_done",   64'(done), 64'd1);
    chk("post_clr_result", result,    64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
